// File: rtl/axi4l_pkg.sv
// Shared encodings for the AXI4-Lite register-file arbiters:
// controller states and AXI response codes.
package axi4l_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_ACK   = 2'b10
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from the
// last winner, with a pointer register updated by the owner on completion.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [N-1:0]     i_req,
    input  logic             i_update,
    input  logic [IDX_W-1:0] i_grant_idx,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;
    logic             found;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of process ordering.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            ptr <= IDX_W'(N - 1);
        end else if (i_update) begin
            ptr <= i_grant_idx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        found       = 1'b0;
        cand        = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N);
            if (!found && i_req[cand]) begin
                found          = 1'b1;
                o_grant[cand]  = 1'b1;
                o_grant_idx    = cand;
            end
        end
    end

endmodule

// File: rtl/axi4l_regfile_wr_arbiter.sv
// Shares one register-file write port among NUM_REQ requesters: round-robin
// grant, address range check, stall-able issue, one-cycle response ack.
module axi4l_regfile_wr_arbiter
    import axi4l_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
    input  logic                             i_axi_clock,
    input  logic                             i_axi_areset,
    input  logic [NUM_REQ-1:0]               i_req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_data,
    input  logic [NUM_REQ*STRB_WIDTH-1:0]    i_req_strb,
    output logic [NUM_REQ-1:0]               o_req_ready,
    output logic [NUM_REQ-1:0]               o_ack,
    output logic [1:0]                       o_ack_resp,
    output logic [ADDR_WIDTH-1:0]            o_rf_addr,
    output logic [DATA_WIDTH-1:0]            o_rf_data,
    output logic [STRB_WIDTH-1:0]            o_rf_strb,
    output logic                             o_rf_valid,
    input  logic                             i_rf_ready,
    input  logic                             i_rf_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t                 state, state_next;
    logic [NUM_REQ-1:0]     arb_req;
    logic [NUM_REQ-1:0]     grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_any;

    logic [ADDR_WIDTH-1:0]  win_addr;
    logic [DATA_WIDTH-1:0]  win_data;
    logic [STRB_WIDTH-1:0]  win_strb;
    logic                   win_oor;

    logic [ADDR_WIDTH-1:0]  cap_addr;
    logic [DATA_WIDTH-1:0]  cap_data;
    logic [STRB_WIDTH-1:0]  cap_strb;
    logic [IDX_W-1:0]       cap_idx;
    logic [1:0]             cap_resp;

    // Requests are only offered in IDLE and never while reset is held, so
    // o_req_ready is zero in every other situation.
    assign arb_req   = (state == ST_IDLE && !i_axi_areset) ? i_req_valid : '0;
    assign grant_any = |grant;
    assign o_req_ready = grant;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .i_clock     (i_axi_clock),
        .i_reset     (i_axi_areset),
        .i_req       (arb_req),
        .i_update    (state == ST_ACK),
        .i_grant_idx (cap_idx),
        .o_grant     (grant),
        .o_grant_idx (grant_idx)
    );

    assign win_addr = i_req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_data = i_req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign win_strb = i_req_strb[int'(grant_idx)*STRB_WIDTH +: STRB_WIDTH];
    assign win_oor  = {1'b0, win_addr} >= (ADDR_WIDTH + 1)'(NUM_REGS);

    always_ff @(posedge i_axi_clock or posedge i_axi_areset) begin
        if (i_axi_areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (grant_any) state_next = win_oor ? ST_ACK : ST_ISSUE;
            ST_ISSUE: if (i_rf_ready) state_next = ST_ACK;
            ST_ACK:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // NOTE: the captured payload is a handful of flops, not a memory array,
    // so it takes the reset and outputs are clean straight out of reset.
    always_ff @(posedge i_axi_clock or posedge i_axi_areset) begin
        if (i_axi_areset) begin
            cap_addr <= '0;
            cap_data <= '0;
            cap_strb <= '0;
            cap_idx  <= '0;
            cap_resp <= RESP_OKAY;
        end else if (state == ST_IDLE && grant_any) begin
            cap_addr <= win_addr;
            cap_data <= win_data;
            cap_strb <= win_strb;
            cap_idx  <= grant_idx;
            cap_resp <= win_oor ? RESP_SLVERR : RESP_OKAY;
        end else if (state == ST_ISSUE && i_rf_ready) begin
            cap_resp <= i_rf_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_comb begin
        o_rf_valid = 1'b0;
        o_rf_addr  = '0;
        o_rf_data  = '0;
        o_rf_strb  = '0;
        o_ack      = '0;
        o_ack_resp = RESP_OKAY;
        if (state == ST_ISSUE) begin
            o_rf_valid = 1'b1;
            o_rf_addr  = cap_addr;
            o_rf_data  = cap_data;
            o_rf_strb  = cap_strb;
        end
        if (state == ST_ACK) begin
            o_ack      = NUM_REQ'(1) << cap_idx;
            o_ack_resp = cap_resp;
        end
    end

endmodule

// File: tb/tb_axi4l_regfile_wr_arbiter.sv
// Directed scoreboard bench for axi4l_regfile_wr_arbiter (2 requesters,
// 10 implemented registers so out-of-range addresses are reachable).
module tb_axi4l_regfile_wr_arbiter;
    import axi4l_pkg::*;

    localparam int NR    = 2;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int SW    = 4;
    localparam int NREGS = 10;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
    } req_t;

    typedef struct {
        int            idx;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [1:0]    resp;
        bit            to_rf;
        bit            err;
        int            stall;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NR-1:0]      i_req_valid = '0;
    logic [NR*AW-1:0]   i_req_addr  = '0;
    logic [NR*DW-1:0]   i_req_data  = '0;
    logic [NR*SW-1:0]   i_req_strb  = '0;
    logic [NR-1:0]      o_req_ready;
    logic [NR-1:0]      o_ack;
    logic [1:0]         o_ack_resp;
    logic [AW-1:0]      o_rf_addr;
    logic [DW-1:0]      o_rf_data;
    logic [SW-1:0]      o_rf_strb;
    logic               o_rf_valid;
    logic               i_rf_ready = 1'b0;
    logic               i_rf_err   = 1'b0;

    req_t q0[$];
    req_t q1[$];
    exp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;

    axi4l_regfile_wr_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .STRB_WIDTH(SW), .NUM_REGS(NREGS)
    ) dut (
        .i_axi_clock  (clk),
        .i_axi_areset (rst),
        .i_req_valid  (i_req_valid),
        .i_req_addr   (i_req_addr),
        .i_req_data   (i_req_data),
        .i_req_strb   (i_req_strb),
        .o_req_ready  (o_req_ready),
        .o_ack        (o_ack),
        .o_ack_resp   (o_ack_resp),
        .o_rf_addr    (o_rf_addr),
        .o_rf_data    (o_rf_data),
        .o_rf_strb    (o_rf_strb),
        .o_rf_valid   (o_rf_valid),
        .i_rf_ready   (i_rf_ready),
        .i_rf_err     (i_rf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_reqs();
        i_req_valid = '0;
        i_req_addr  = '0;
        i_req_data  = '0;
        i_req_strb  = '0;
        if (q0.size() > 0) begin
            i_req_valid[0]      = 1'b1;
            i_req_addr[0 +: AW] = q0[0].addr;
            i_req_data[0 +: DW] = q0[0].data;
            i_req_strb[0 +: SW] = q0[0].strb;
        end
        if (q1.size() > 0) begin
            i_req_valid[1]       = 1'b1;
            i_req_addr[AW +: AW] = q1[0].addr;
            i_req_data[DW +: DW] = q1[0].data;
            i_req_strb[SW +: SW] = q1[0].strb;
        end
    endtask

    // Queue a request on requester k and the response the model predicts.
    task automatic add(input int k, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic [SW-1:0] strb, input int stall, input bit err);
        req_t r;
        exp_t e;
        r.addr = addr; r.data = data; r.strb = strb;
        if (k == 0) q0.push_back(r); else q1.push_back(r);
        e.idx = k; e.addr = addr; e.data = data; e.strb = strb;
        e.stall = stall; e.err = err;
        e.to_rf = (int'(addr) < NREGS);
        e.resp  = (!e.to_rf || err) ? RESP_SLVERR : RESP_OKAY;
        sb.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(o_req_ready), 64'(0));
        chk({tag, "_ack"},   64'(o_ack), 64'(0));
        chk({tag, "_resp"},  64'(o_ack_resp), 64'(0));
        chk({tag, "_rf"},    64'({o_rf_valid, o_rf_addr, o_rf_strb}), 64'(0));
        chk({tag, "_data"},  64'(o_rf_data), 64'(0));
    endtask

    task automatic do_reset();
        req_t r;
        q0.delete(); q1.delete(); sb.delete();
        i_rf_ready = 1'b0; i_rf_err = 1'b0;
        rst = 1'b1;
        r.addr = 4'd1; r.data = 32'hA5A5A5A5; r.strb = 4'hF;
        q0.push_back(r); q1.push_back(r);
        drive_reqs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        q0.delete(); q1.delete();
        drive_reqs();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Run the DUT until n transactions have been acknowledged, checking every
    // observed grant, issue and ack against the scoreboard head.
    task automatic serve(input int n);
        int done = 0;
        int cyc = 0;
        int gcyc = 0;
        int rf_cnt = 0;
        int granted;
        while (done < n && cyc < 30 * n) begin
            @(negedge clk);
            cyc++;
            granted = -1;
            if (o_req_ready != '0) begin
                if (sb.size() == 0) chk("unexpected_grant", 64'(o_req_ready), 64'(0));
                else begin
                    chk("grant", 64'(o_req_ready), 64'(1) << sb[0].idx);
                    granted = sb[0].idx;
                    gcyc = cyc;
                    rf_cnt = 0;
                end
            end
            if (o_rf_valid) begin
                if (sb.size() == 0) chk("unexpected_rf_valid", 64'(o_rf_valid), 64'(0));
                else begin
                    chk("rf_valid_allowed", 64'(o_rf_valid), 64'(sb[0].to_rf));
                    chk("rf_addr", 64'(o_rf_addr), 64'(sb[0].addr));
                    chk("rf_data", 64'(o_rf_data), 64'(sb[0].data));
                    chk("rf_strb", 64'(o_rf_strb), 64'(sb[0].strb));
                    chk("ready_during_issue", 64'(o_req_ready), 64'(0));
                    if (rf_cnt == 0) chk("rf_latency", 64'(cyc), 64'(gcyc + 1));
                    rf_cnt++;
                    i_rf_ready = (rf_cnt > sb[0].stall);
                    i_rf_err   = i_rf_ready ? sb[0].err : 1'b1;
                end
            end else begin
                chk("rf_idle_zero", 64'({o_rf_addr, o_rf_strb}), 64'(0));
                chk("rf_idle_data", 64'(o_rf_data), 64'(0));
            end
            if (o_ack != '0) begin
                if (sb.size() == 0) chk("unexpected_ack", 64'(o_ack), 64'(0));
                else begin
                    chk("ack", 64'(o_ack), 64'(1) << sb[0].idx);
                    chk("ack_resp", 64'(o_ack_resp), 64'(sb[0].resp));
                    chk("ack_latency", 64'(cyc),
                        64'(sb[0].to_rf ? gcyc + 2 + sb[0].stall : gcyc + 1));
                    chk("issue_cycles", 64'(rf_cnt), 64'(sb[0].to_rf ? sb[0].stall + 1 : 0));
                    chk("ready_during_ack", 64'(o_req_ready), 64'(0));
                    void'(sb.pop_front());
                    done++;
                end
                i_rf_ready = 1'b0;
                i_rf_err   = 1'b0;
            end else begin
                chk("resp_idle_zero", 64'(o_ack_resp), 64'(0));
            end
            @(posedge clk); #1;
            if (granted == 0) void'(q0.pop_front());
            else if (granted == 1) void'(q1.pop_front());
            drive_reqs();
        end
        if (done < n) chk("serve_timeout", 64'(done), 64'(n));
    endtask

    initial begin
        bit   seen;
        req_t r;

        // Reset values, then a single in-range write from requester 0.
        do_reset();
        add(0, 4'd3, 32'hDEADBEEF, 4'hF, 0, 1'b0);
        drive_reqs();
        serve(1);

        // Contention from reset: both requesters continuously valid.
        do_reset();
        add(0, 4'd1, 32'h11111111, 4'hF, 0, 1'b0);
        add(1, 4'd2, 32'h22222222, 4'hC, 0, 1'b0);
        add(0, 4'd5, 32'h55555555, 4'h3, 0, 1'b0);
        add(1, 4'd6, 32'h66666666, 4'h1, 0, 1'b0);
        // Scoreboard order must follow the round-robin 0,1,0,1.
        sb.delete();
        begin
            exp_t e;
            e.to_rf = 1'b1; e.err = 1'b0; e.stall = 0; e.resp = RESP_OKAY;
            e.idx = 0; e.addr = 4'd1; e.data = 32'h11111111; e.strb = 4'hF; sb.push_back(e);
            e.idx = 1; e.addr = 4'd2; e.data = 32'h22222222; e.strb = 4'hC; sb.push_back(e);
            e.idx = 0; e.addr = 4'd5; e.data = 32'h55555555; e.strb = 4'h3; sb.push_back(e);
            e.idx = 1; e.addr = 4'd6; e.data = 32'h66666666; e.strb = 4'h1; sb.push_back(e);
        end
        drive_reqs();
        serve(4);

        // Register file stalls for 3 cycles.
        add(0, 4'd7, 32'hCAFEF00D, 4'h5, 3, 1'b0);
        drive_reqs();
        serve(1);

        // Out-of-range addresses (12 and the first invalid index 10), then
        // the last valid register rejected by the register file.
        add(1, 4'd12, 32'h0BADF00D, 4'hF, 0, 1'b0);
        add(1, 4'd10, 32'h12345678, 4'hA, 0, 1'b0);
        drive_reqs();
        serve(2);
        add(0, 4'd9, 32'h99999999, 4'hF, 1, 1'b1);
        drive_reqs();
        serve(1);

        // Reset while a write is held in ISSUE; pointer currently points at 0.
        q0.delete(); q1.delete(); sb.delete();
        r.addr = 4'd4; r.data = 32'h44444444; r.strb = 4'hF;
        q1.push_back(r);
        drive_reqs();
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            if (o_req_ready != '0) seen = 1'b1;
        end
        chk("pre_reset_grant", 64'(o_req_ready), 64'(2'b10));
        @(posedge clk); #1;
        void'(q1.pop_front());
        add(0, 4'd8, 32'h88888888, 4'h6, 0, 1'b0);
        add(1, 4'd0, 32'h00C0FFEE, 4'h9, 0, 1'b0);
        drive_reqs();
        @(negedge clk);
        chk("pre_reset_rf_valid", 64'(o_rf_valid), 64'(1));
        #1 rst = 1'b1;
        #1 check_all_zero("mid_issue_reset");
        repeat (2) begin
            @(negedge clk);
            chk("reset_no_ack", 64'(o_ack), 64'(0));
            chk("reset_no_rf", 64'(o_rf_valid), 64'(0));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1 chk("post_reset_ready", 64'(o_req_ready), 64'(2'b01));
        serve(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4l_regfile_wr_arbiter.md
Name: axi4l_regfile_wr_arbiter

Overview:
Shares one register-file write port between NUM_REQ write requesters: the AXI4-Lite write channel, plus internal hardware update sources. Each requester presents a valid/ready write request. The block picks one requester by round-robin, applies an address range check, and issues the write to the register file with a stall-able valid/ready handshake. It then returns a one-cycle acknowledge carrying an AXI response code to the winning requester.

Parameters:
NUM_REQ, 2, number of write requesters (2..8)
ADDR_WIDTH, 4, register address width
DATA_WIDTH, 32, register data width
STRB_WIDTH, DATA_WIDTH/8, byte-strobe width
NUM_REGS, 2**ADDR_WIDTH, count of implemented registers; addresses >= NUM_REGS are out of range

Ports:
i_axi_clock  in  1  clock
i_axi_areset  in  1  asynchronous reset, active-high
i_req_valid  in  NUM_REQ  per-requester request valid
i_req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
i_req_data  in  NUM_REQ*DATA_WIDTH  flattened write data
i_req_strb  in  NUM_REQ*STRB_WIDTH  flattened byte strobes
o_req_ready  out  NUM_REQ  one-hot acceptance pulse
o_ack  out  NUM_REQ  one-hot completion pulse
o_ack_resp  out  2  response code for the current o_ack: 2'b00 OKAY, 2'b10 SLVERR
o_rf_addr  out  ADDR_WIDTH  register-file write address
o_rf_data  out  DATA_WIDTH  register-file write data
o_rf_strb  out  STRB_WIDTH  register-file byte strobes
o_rf_valid  out  1  register-file write valid
i_rf_ready  in  1  register file accepts the write
i_rf_err  in  1  register file rejects the write; sampled with i_rf_ready

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; all outputs 0; captured payload 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 wins first.
  - Reset mid-transaction drops the transaction. No o_ack is issued for it.
- States: IDLE, ISSUE, ACK.
- IDLE:
  - o_req_ready is combinational. It is the one-hot grant to the first requester with valid=1, searching from pointer+1 upward and wrapping modulo NUM_REQ. It is 0 when no requester is valid.
  - On grant, the winner's addr/data/strb and winner index are registered.
  - If addr >= NUM_REGS: resp = SLVERR, next state = ACK, and no register-file access is made.
  - Otherwise: next state = ISSUE.
- ISSUE:
  - o_rf_valid=1 and o_rf_addr/data/strb driven from the captured registers, held stable until i_rf_ready=1.
  - On i_rf_ready: resp = i_rf_err ? SLVERR : OKAY; next state = ACK.
- ACK:
  - o_ack[winner]=1 for exactly one cycle, with o_ack_resp valid in the same cycle.
  - Pointer updates to the winner index; next state = IDLE.
- Latency: grant at cycle 0 → o_rf_valid at cycle 1 → o_ack at cycle 2 when i_rf_ready=1 at cycle 1. Each stall cycle adds one. An out-of-range request acks at cycle 1.
- Throughput: at most one write per 3 cycles. No new grant is made while in ISSUE or ACK; o_req_ready stays 0.
- Requester contract:
  - valid stays high and payload stays stable until o_req_ready.
  - valid dropped before grant has no effect.
  - After o_req_ready, the requester drops valid or presents its next request.
- Simultaneous requests: exactly one grant per IDLE cycle. The pointer guarantees each continuously valid requester is served within NUM_REQ transactions.
- o_rf_* outputs are 0 whenever o_rf_valid=0.
- o_ack_resp is 0 whenever o_ack=0.
- Strobes pass through unmodified; byte masking is the register file's job.

Decomposition:
- Shared package axi4l_pkg: state encodings (IDLE 2'b00, ISSUE 2'b01, ACK 2'b10); RESP_OKAY 2'b00; RESP_SLVERR 2'b10.
- Sub-module rr_arbiter #(N):
  - Inputs i_req and i_update/i_grant_idx.
  - Output o_grant (combinational one-hot) and o_grant_idx.
  - Owns the pointer register with asynchronous active-high reset.
  - Reusable for the read-side arbiter.

Test Plan:
- Single request: requester 0 writes addr 3, data 0xDEADBEEF, strb 4'hF, i_rf_ready=1 → o_req_ready=2'b01 at cycle 0, o_rf_valid with addr 3 and data 0xDEADBEEF at cycle 1, o_ack=2'b01 with resp 00 at cycle 2.
- Contention: both requesters valid continuously for 4 transactions from reset → grant order 0,1,0,1. Each o_ack matches its grant, and each transaction's addr/data is unmixed.
- Stall: i_rf_ready held 0 for 3 cycles → o_rf_valid and payload stable for 4 cycles; o_ack at cycle 5; o_req_ready stays 0 throughout.
- Errors: NUM_REGS=10 with addr 12 → o_ack at cycle 1 with resp 2'b10 and o_rf_valid never asserted. Separately, i_rf_err=1 with i_rf_ready → resp 2'b10.
- Reset mid-ISSUE: assert i_axi_areset while o_rf_valid=1 → all outputs 0 immediately and no o_ack. After release with both requesters valid, requester 0 is granted first.
